// File: rtl/div_rem_pkg.sv
// Shared widths, default depth and the result entry layout for the divider post stage.
package div_rem_pkg;

  localparam int DATA_W        = 32;
  localparam int CORE_NUM_W    = 3;
  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [CORE_NUM_W-1:0] core_num;
  } result_entry_t;

  // Two's-complement negation of the selected magnitude when the sign flag is set.
  function automatic logic [DATA_W-1:0] sign_correct(input logic neg, input logic [DATA_W-1:0] mag);
    return neg ? (~mag + DATA_W'(1)) : mag;
  endfunction

endpackage

// File: rtl/div_rem_fifo.sv
// Generic show-ahead FIFO: the head is read straight from registered storage, with no read latency.
module div_rem_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CNT_W'(DEPTH));
    pop_ok  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push_ok = push_i && (!full_o || pop_ok);
    drop_o  = push_i && full_o && !pop_ok;
    head_o  = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/div_rem_post.sv
// Divider post stage: sign-corrects quotient/remainder and queues results in order.
// Optional drop counter output enabled by defining DIV_REM_POST_DROP_CNT_EN.
module div_rem_post
  import div_rem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready_in,
  input  logic                  sign_state_in,
  input  logic                  rem_or_div_in,
  input  logic [CORE_NUM_W-1:0] core_num_in,
  input  logic [DATA_W-1:0]     dividend_in,
  input  logic [DATA_W-1:0]     proc_data_in,
  input  logic                  result_ready,
  output logic                  result_valid,
  output logic [DATA_W-1:0]     result_data,
  output logic [CORE_NUM_W-1:0] result_core_num,
`ifdef DIV_REM_POST_DROP_CNT_EN
  output logic [7:0]            drop_cnt,
`endif
  output logic                  overflow_out
);

  localparam int ENTRY_W = DATA_W + CORE_NUM_W;

  result_entry_t push_entry, head_entry;
  logic          fifo_full, fifo_empty, fifo_drop;
  logic          overflow_q, overflow_d;

  always_comb begin
    push_entry.data     = sign_correct(sign_state_in, rem_or_div_in ? dividend_in : proc_data_in);
    push_entry.core_num = core_num_in;
  end

  div_rem_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ready_in),
    .push_data_i (push_entry),
    .pop_i       (result_ready),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop),
    .head_o      (head_entry)
  );

  assign result_valid    = !fifo_empty;
  assign result_data     = head_entry.data;
  assign result_core_num = head_entry.core_num;
  assign overflow_d      = overflow_q | fifo_drop;
  assign overflow_out    = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

`ifdef DIV_REM_POST_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturates so a long overflow burst never wraps back to a small count.
  assign drop_cnt_d = (fifo_drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  assign drop_cnt   = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end
`else
  logic unused_full;
  assign unused_full = fifo_full;
`endif

endmodule
